// File: rtl/stack_pkg.sv
// Shared definitions for the stack command front-end: op encodings, FSM states, counter sizing.
// STACK_CMD_CLEAR_EN adds the CLR state used by the CLEAR command.
package stack_pkg;

   localparam logic [1:0] OP_PUSH  = 2'b00;
   localparam logic [1:0] OP_POP   = 2'b01;
   localparam logic [1:0] OP_RSVD  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StPush,
      StPop,
      StResp
`ifdef STACK_CMD_CLEAR_EN
      , StClr
`endif
   } state_e;

   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/stack_cmd_ctrl_if.sv
// Command, response and stack-side signals of the stack command front-end.
// slave: the controller; master: the upstream/stack side.
interface stack_cmd_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 3
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [1:0]            cmd_op;
   logic [DATA_WIDTH-1:0] cmd_data;
   logic                  stk_push;
   logic                  stk_pop;
   logic [DATA_WIDTH-1:0] stk_write_data;
   logic [DATA_WIDTH-1:0] stk_read_data;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_data;
   logic                  rsp_err;
   logic [CNT_WIDTH-1:0]  count;
   logic                  full;
   logic                  empty;

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, stk_read_data, rsp_ready,
      output cmd_ready, stk_push, stk_pop, stk_write_data, rsp_valid, rsp_data, rsp_err,
             count, full, empty
   );

   modport master (
      output cmd_valid, cmd_op, cmd_data, stk_read_data, rsp_ready,
      input  cmd_ready, stk_push, stk_pop, stk_write_data, rsp_valid, rsp_data, rsp_err,
             count, full, empty
   );
endinterface

// File: rtl/stack_cmd_ctrl.sv
// Push/pop command front-end for a LIFO stack with its own occupancy count and one response per
// command. Defining STACK_CMD_CLEAR_EN turns op 11 into CLEAR; otherwise op 11 is rejected.
module stack_cmd_ctrl
   import stack_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int STACK_SIZE = 4,
   parameter int CNT_WIDTH  = cnt_width(STACK_SIZE)
) (
   input logic             clk,
   input logic             reset,
   stack_cmd_ctrl_if.slave bus
);

   localparam logic [CNT_WIDTH-1:0] L_FULL = CNT_WIDTH'(STACK_SIZE);
   localparam logic [CNT_WIDTH-1:0] L_ONE  = CNT_WIDTH'(1);

   state_e                r_state;
   state_e                w_state_d;
   logic [CNT_WIDTH-1:0]  r_count;
   logic                  r_stk_push;
   logic                  r_stk_pop;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rsp_data;
   logic                  r_rsp_err;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_accept;
   logic                  w_reject;
   logic                  w_pop_next;

   assign w_full   = (r_count == L_FULL);
   assign w_empty  = (r_count == '0);
   assign w_accept = bus.cmd_valid && (r_state == StIdle);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_reject  = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (bus.cmd_valid) begin
               case (bus.cmd_op)
                  OP_PUSH: begin
                     w_reject  = w_full;
                     w_state_d = w_full ? StResp : StPush;
                  end
                  OP_POP: begin
                     w_reject  = w_empty;
                     w_state_d = w_empty ? StResp : StPop;
                  end
`ifdef STACK_CMD_CLEAR_EN
                  // Clearing an empty stack is a successful no-op.
                  OP_CLEAR: w_state_d = w_empty ? StResp : StClr;
`endif
                  default: begin
                     w_reject  = 1'b1;
                     w_state_d = StResp;
                  end
               endcase
            end
         end
         StPush:  w_state_d = StResp;
         StPop:   w_state_d = StResp;
`ifdef STACK_CMD_CLEAR_EN
         StClr:   w_state_d = (r_count == L_ONE) ? StResp : StClr;
`endif
         StResp:  w_state_d = bus.rsp_ready ? StIdle : StResp;
         default: w_state_d = StIdle;
      endcase
   end

`ifdef STACK_CMD_CLEAR_EN
   assign w_pop_next = (w_state_d == StPop) || (w_state_d == StClr);
`else
   assign w_pop_next = (w_state_d == StPop);
`endif

   // Stack pulses are registered from the next state so each lands in the matching state cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count    <= '0;
         r_stk_push <= 1'b0;
         r_stk_pop  <= 1'b0;
         r_wdata    <= '0;
         r_rsp_data <= '0;
         r_rsp_err  <= 1'b0;
      end else begin
         r_stk_push <= (w_state_d == StPush);
         r_stk_pop  <= w_pop_next;
         case (r_state)
            StIdle: begin
               if (w_accept) begin
                  if (w_state_d == StPush) begin
                     r_wdata <= bus.cmd_data;
                  end
                  if (w_state_d == StResp) begin
                     r_rsp_err  <= w_reject;
                     r_rsp_data <= '0;
                  end
               end
            end
            StPush: begin
               r_count    <= r_count + L_ONE;
               r_rsp_data <= '0;
               r_rsp_err  <= 1'b0;
            end
            StPop: begin
               r_count    <= r_count - L_ONE;
               r_rsp_data <= bus.stk_read_data;
               r_rsp_err  <= 1'b0;
            end
`ifdef STACK_CMD_CLEAR_EN
            StClr: begin
               r_count    <= r_count - L_ONE;
               r_rsp_data <= '0;
               r_rsp_err  <= 1'b0;
            end
`endif
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.cmd_ready = (r_state == StIdle);
      bus.rsp_valid = (r_state == StResp);
   end

   assign bus.stk_push       = r_stk_push;
   assign bus.stk_pop        = r_stk_pop;
   assign bus.stk_write_data = r_wdata;
   assign bus.rsp_data       = r_rsp_data;
   assign bus.rsp_err        = r_rsp_err;
   assign bus.count          = r_count;
   assign bus.full           = w_full;
   assign bus.empty          = w_empty;

endmodule

// File: tb/tb_stack_cmd_ctrl.sv
// Directed bench for stack_cmd_ctrl with a behavioural LIFO model on the stack side.
// Clear-specific vectors run only when STACK_CMD_CLEAR_EN is defined.
module tb_stack_cmd_ctrl;
   import stack_pkg::*;

   localparam int DW = 8;
   localparam int SS = 4;
   localparam int CW = cnt_width(SS);

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   stack_cmd_ctrl_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) u_if ();

   stack_cmd_ctrl #(
      .DATA_WIDTH(DW),
      .STACK_SIZE(SS),
      .CNT_WIDTH (CW)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (u_if)
   );

   // Stack model: top of stack visible combinationally, updated on the pulses.
   logic [DW-1:0] mem [2**CW];
   logic [CW-1:0] sp;
   int            n_push    = 0;
   int            n_pop     = 0;
   logic          both_seen = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         sp <= '0;
      end else if (u_if.stk_push) begin
         mem[sp] <= u_if.stk_write_data;
         sp      <= sp + 1'b1;
      end else if (u_if.stk_pop && sp != '0) begin
         sp <= sp - 1'b1;
      end
      if (u_if.stk_push) n_push <= n_push + 1;
      if (u_if.stk_pop)  n_pop  <= n_pop + 1;
      if (u_if.stk_push && u_if.stk_pop) both_seen <= 1'b1;
   end

   assign u_if.stk_read_data = (sp != '0) ? mem[sp - 1'b1] : '0;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present one command at a negedge while idle; returns at the negedge of cycle T+1.
   task automatic issue(input logic [1:0] op, input logic [DW-1:0] data);
      int guard = 0;
      while (!u_if.cmd_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      u_if.cmd_valid = 1'b1;
      u_if.cmd_op    = op;
      u_if.cmd_data  = data;
      @(negedge clk);
      u_if.cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string tag);
      int guard = 0;
      while (!u_if.rsp_valid && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check_val(tag, 32'(u_if.rsp_valid), 32'd1);
   endtask

   task automatic run_cmd(input string tag, input logic [1:0] op, input logic [DW-1:0] data,
                          input logic [DW-1:0] exp_data, input logic exp_err, input int exp_lat,
                          input logic exp_push, input logic exp_pop);
      int   lat;
      logic p1;
      logic q1;
      issue(op, data);
      lat = 1;
      p1  = u_if.stk_push;
      q1  = u_if.stk_pop;
      while (!u_if.rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check_val({tag, "_lat"},  32'(lat),           32'(exp_lat));
      check_val({tag, "_data"}, 32'(u_if.rsp_data), 32'(exp_data));
      check_val({tag, "_err"},  32'(u_if.rsp_err),  32'(exp_err));
      check_val({tag, "_push"}, 32'(p1),            32'(exp_push));
      check_val({tag, "_pop"},  32'(q1),            32'(exp_pop));
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_rsp_valid"}, 32'(u_if.rsp_valid), 32'd0);
      check_val({tag, "_rsp_data"},  32'(u_if.rsp_data),  32'd0);
      check_val({tag, "_rsp_err"},   32'(u_if.rsp_err),   32'd0);
      check_val({tag, "_count"},     32'(u_if.count),     32'd0);
      check_val({tag, "_cmd_ready"}, 32'(u_if.cmd_ready), 32'd1);
      check_val({tag, "_stk_push"},  32'(u_if.stk_push),  32'd0);
      check_val({tag, "_stk_pop"},   32'(u_if.stk_pop),   32'd0);
      check_val({tag, "_wdata"},     32'(u_if.stk_write_data), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int np0;
      int nq0;
      u_if.cmd_valid = 1'b0;
      u_if.cmd_op    = OP_PUSH;
      u_if.cmd_data  = '0;
      u_if.rsp_ready = 1'b1;
      reset          = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_reset_outputs("reset");
      check_val("reset_empty", 32'(u_if.empty), 32'd1);
      check_val("reset_full",  32'(u_if.full),  32'd0);

      run_cmd("push11", OP_PUSH, 8'h11, 8'h00, 1'b0, 2, 1'b1, 1'b0);
      run_cmd("push22", OP_PUSH, 8'h22, 8'h00, 1'b0, 2, 1'b1, 1'b0);
      run_cmd("push33", OP_PUSH, 8'h33, 8'h00, 1'b0, 2, 1'b1, 1'b0);
      check_val("count3", 32'(u_if.count), 32'd3);

      run_cmd("pop33", OP_POP, 8'h00, 8'h33, 1'b0, 2, 1'b0, 1'b1);
      run_cmd("pop22", OP_POP, 8'h00, 8'h22, 1'b0, 2, 1'b0, 1'b1);
      run_cmd("pop11", OP_POP, 8'h00, 8'h11, 1'b0, 2, 1'b0, 1'b1);
      check_val("empty_after_pops", 32'(u_if.empty), 32'd1);

      nq0 = n_pop;
      run_cmd("pop_empty", OP_POP, 8'h00, 8'h00, 1'b1, 1, 1'b0, 1'b0);
      check_val("pop_empty_count", 32'(u_if.count), 32'd0);
      run_cmd("rsvd", OP_RSVD, 8'h99, 8'h00, 1'b1, 1, 1'b0, 1'b0);
`ifdef STACK_CMD_CLEAR_EN
      run_cmd("clear_empty", OP_CLEAR, 8'h00, 8'h00, 1'b0, 1, 1'b0, 1'b0);
`else
      run_cmd("clear_rej", OP_CLEAR, 8'h00, 8'h00, 1'b1, 1, 1'b0, 1'b0);
`endif
      check_val("no_pop_on_reject", 32'(n_pop - nq0), 32'd0);

      for (int i = 0; i < SS; i++) begin
         run_cmd("fill", OP_PUSH, 8'hA0 + 8'(i), 8'h00, 1'b0, 2, 1'b1, 1'b0);
      end
      check_val("full_set", 32'(u_if.full), 32'd1);
      np0 = n_push;
      run_cmd("push_full", OP_PUSH, 8'h55, 8'h00, 1'b1, 1, 1'b0, 1'b0);
      check_val("push_full_pulses", 32'(n_push - np0), 32'd0);
      check_val("full_stays", 32'(u_if.full), 32'd1);
      check_val("full_count", 32'(u_if.count), 32'd4);
      run_cmd("pop_top", OP_POP, 8'h00, 8'hA3, 1'b0, 2, 1'b0, 1'b1);

      // Backpressure on the response holds it and blocks the next command.
      pulse_reset();
      run_cmd("pushAA", OP_PUSH, 8'hAA, 8'h00, 1'b0, 2, 1'b1, 1'b0);
      @(negedge clk);
      u_if.rsp_ready = 1'b0;
      issue(OP_POP, 8'h00);
      wait_rsp("hold_rsp");
      u_if.cmd_valid = 1'b1;
      u_if.cmd_op    = OP_PUSH;
      u_if.cmd_data  = 8'h77;
      np0 = n_push;
      for (int i = 0; i < 5; i++) begin
         check_val("hold_valid", 32'(u_if.rsp_valid), 32'd1);
         check_val("hold_data",  32'(u_if.rsp_data),  32'hAA);
         check_val("hold_ready", 32'(u_if.cmd_ready), 32'd0);
         @(negedge clk);
      end
      check_val("hold_no_push", 32'(n_push - np0), 32'd0);
      u_if.rsp_ready = 1'b1;
      @(negedge clk);
      check_val("release_ready", 32'(u_if.cmd_ready), 32'd1);
      check_val("release_valid", 32'(u_if.rsp_valid), 32'd0);
      @(negedge clk);
      check_val("late_push_pulse", 32'(u_if.stk_push), 32'd1);
      u_if.cmd_valid = 1'b0;
      wait_rsp("late_push_rsp");
      check_val("late_push_err", 32'(u_if.rsp_err), 32'd0);
      @(negedge clk);
      check_val("late_push_count", 32'(u_if.count), 32'd1);

      // Reset while a response is pending.
      u_if.rsp_ready = 1'b0;
      issue(OP_POP, 8'h00);
      wait_rsp("resp77");
      check_val("resp77_data", 32'(u_if.rsp_data), 32'h77);
      pulse_reset();
      check_reset_outputs("rst_resp");
      issue(OP_POP, 8'h00);
      wait_rsp("resp_err");
      check_val("resp_err_set", 32'(u_if.rsp_err), 32'd1);
      pulse_reset();
      check_reset_outputs("rst_err");
      u_if.rsp_ready = 1'b1;

`ifdef STACK_CMD_CLEAR_EN
      for (int i = 0; i < 3; i++) run_cmd("cfill", OP_PUSH, 8'h30 + 8'(i), 8'h00, 1'b0, 2, 1'b1, 1'b0);
      nq0 = n_pop;
      run_cmd("clear3", OP_CLEAR, 8'h00, 8'h00, 1'b0, 4, 1'b0, 1'b1);
      check_val("clear3_pulses", 32'(n_pop - nq0), 32'd3);
      check_val("clear3_count", 32'(u_if.count), 32'd0);
      for (int i = 0; i < 3; i++) run_cmd("cfill2", OP_PUSH, 8'h40 + 8'(i), 8'h00, 1'b0, 2, 1'b1, 1'b0);
      issue(OP_CLEAR, 8'h00);
      check_val("clr_active_pop", 32'(u_if.stk_pop), 32'd1);
      pulse_reset();
      check_reset_outputs("rst_clr");
`endif

      check_val("push_pop_exclusive", 32'(both_seen), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
